// File: rtl/cdb_broadcast.sv
// rtl/cdb_broadcast.sv - common data bus arbiter: FU completions to registered CDB lanes with an in-order overflow queue
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROBLEN
`define ROBLEN 32
`endif

module cdb_broadcast #(
    parameter int NUM_FU    = 4,
    parameter int CDB_LANES = 3,
    parameter int BUF_DEPTH = 8,
    parameter int TAG_W     = $clog2(`ROBLEN)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                squash_flag,
    input  logic [NUM_FU-1:0]                   fu_valid,
    input  logic [NUM_FU-1:0][TAG_W-1:0]        fu_tag,
    input  logic [NUM_FU-1:0][`XLEN-1:0]        fu_value,
    output logic                                fu_ready,
    output logic [CDB_LANES-1:0]                cdb_valid,
    output logic [CDB_LANES-1:0][TAG_W-1:0]     cdb_tag,
    output logic [CDB_LANES-1:0][`XLEN-1:0]     cdb_value,
    output logic [$clog2(BUF_DEPTH):0]          buf_count
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    logic [TAG_W-1:0]             q_tag   [BUF_DEPTH];
    logic [`XLEN-1:0]             q_value [BUF_DEPTH];
    logic [PW-1:0]                head;
    logic [PW-1:0]                tail;
    logic [PW-1:0]                head_next;
    logic [PW-1:0]                tail_next;
    logic [CW-1:0]                count_next;

    logic [NUM_FU-1:0]            accept;
    int                           rank [NUM_FU];
    int                           cnt;
    int                           n_acc;
    int                           n_lanes;
    int                           n_pop;
    int                           n_push;
    int                           push_start;
    logic [NUM_FU-1:0]            wr_en;
    logic [PW-1:0]                wr_idx [NUM_FU];

    logic [CDB_LANES-1:0]             lane_valid;
    logic [CDB_LANES-1:0][TAG_W-1:0]  lane_tag;
    logic [CDB_LANES-1:0][`XLEN-1:0]  lane_value;

    assign fu_ready = (buf_count < CW'(BUF_DEPTH));

    always_comb begin
        accept     = '0;
        cnt        = int'(buf_count);
        n_acc      = 0;
        // rank = position of an accepted result among this cycle's accepted results
        for (int i = 0; i < NUM_FU; i++) begin
            accept[i] = fu_valid[i] & fu_ready & ~squash_flag;
            rank[i]   = n_acc;
            if (accept[i]) begin
                n_acc = n_acc + 1;
            end
        end
        n_lanes    = (cnt + n_acc < CDB_LANES) ? cnt + n_acc : CDB_LANES;
        n_pop      = (cnt < CDB_LANES) ? cnt : CDB_LANES;
        push_start = (cnt < CDB_LANES) ? CDB_LANES - cnt : 0;

        // Candidate list: queued entries oldest first, then new results by FU index
        for (int j = 0; j < CDB_LANES; j++) begin
            lane_valid[j] = 1'b0;
            lane_tag[j]   = '0;
            lane_value[j] = '0;
            if (j < cnt) begin
                lane_valid[j] = 1'b1;
                lane_tag[j]   = q_tag[head + PW'(j)];
                lane_value[j] = q_value[head + PW'(j)];
            end else begin
                for (int i = 0; i < NUM_FU; i++) begin
                    if (accept[i] && (cnt + rank[i] == j)) begin
                        lane_valid[j] = 1'b1;
                        lane_tag[j]   = fu_tag[i];
                        lane_value[j] = fu_value[i];
                    end
                end
            end
        end

        n_push = 0;
        for (int i = 0; i < NUM_FU; i++) begin
            wr_en[i]  = 1'b0;
            wr_idx[i] = tail;
            if (accept[i] && (rank[i] >= push_start)) begin
                wr_en[i]  = 1'b1;
                wr_idx[i] = tail + PW'(rank[i] - push_start);
                n_push    = n_push + 1;
            end
        end

        count_next = CW'(cnt + n_acc - n_lanes);
        head_next  = head + PW'(n_pop);
        tail_next  = tail + PW'(n_push);
    end

    always_ff @(posedge clock) begin
        if (!reset || squash_flag) begin
            head      <= '0;
            tail      <= '0;
            buf_count <= '0;
            cdb_valid <= '0;
            cdb_tag   <= '0;
            cdb_value <= '0;
        end else begin
            head      <= head_next;
            tail      <= tail_next;
            buf_count <= count_next;
            cdb_valid <= lane_valid;
            cdb_tag   <= lane_tag;
            cdb_value <= lane_value;
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live
    always_ff @(posedge clock) begin
        if (reset && !squash_flag) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (wr_en[i]) begin
                    q_tag[wr_idx[i]]   <= fu_tag[i];
                    q_value[wr_idx[i]] <= fu_value[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_cdb_broadcast.sv
// tb/tb_cdb_broadcast.sv - scoreboard bench for cdb_broadcast
`timescale 1ns/1ps

module tb_cdb_broadcast;
    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 squash_flag = 1'b0;
    logic [3:0]           fu_valid = '0;
    logic [3:0][4:0]      fu_tag = '0;
    logic [3:0][31:0]     fu_value = '0;
    logic                 fu_ready;
    logic [2:0]           cdb_valid;
    logic [2:0][4:0]      cdb_tag;
    logic [2:0][31:0]     cdb_value;
    logic [3:0]           buf_count;

    int checks = 0;
    int errors = 0;
    bit started = 0;
    int seq = 0;
    logic [36:0] sb [$];
    logic [3:0][4:0]  tv;
    logic [3:0][31:0] dv;

    cdb_broadcast dut (
        .clock       (clock),
        .reset       (reset),
        .squash_flag (squash_flag),
        .fu_valid    (fu_valid),
        .fu_tag      (fu_tag),
        .fu_value    (fu_value),
        .fu_ready    (fu_ready),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_value   (cdb_value),
        .buf_count   (buf_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic fresh();
        for (int i = 0; i < 4; i++) begin
            tv[i] = 5'(seq);
            dv[i] = 32'hC0DE_0000 + 32'(seq);
            seq++;
        end
    endtask

    task automatic step(input logic rs, input logic sq, input logic [3:0] v,
                        input logic [3:0][4:0] t, input logic [3:0][31:0] d);
        int p;
        logic [36:0] e;
        if (started) begin
            check("fu_ready", 32'(fu_ready), 32'(sb.size() < 8));
        end
        reset = rs;
        squash_flag = sq;
        fu_valid = v;
        fu_tag = t;
        fu_value = d;
        if (!rs || sq) begin
            sb.delete();
        end else if (sb.size() < 8) begin
            for (int i = 0; i < 4; i++) begin
                if (v[i]) sb.push_back({t[i], d[i]});
            end
        end
        @(posedge clock);
        #1;
        p = (sb.size() < 3) ? sb.size() : 3;
        for (int j = 0; j < 3; j++) begin
            if (j < p) begin
                e = sb.pop_front();
                check($sformatf("lane%0d_valid", j), 32'(cdb_valid[j]), 32'd1);
                check($sformatf("lane%0d_tag", j), 32'(cdb_tag[j]), 32'(e[36:32]));
                check($sformatf("lane%0d_value", j), cdb_value[j], e[31:0]);
            end else begin
                check($sformatf("lane%0d_idle_valid", j), 32'(cdb_valid[j]), 32'd0);
                check($sformatf("lane%0d_idle_tag", j), 32'(cdb_tag[j]), 32'd0);
                check($sformatf("lane%0d_idle_value", j), cdb_value[j], 32'd0);
            end
        end
        check("buf_count", 32'(buf_count), 32'(sb.size()));
        started = 1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 4'b0000, '0, '0);
    endtask

    task automatic flood(input int n);
        for (int k = 0; k < n; k++) begin
            fresh();
            step(1'b1, 1'b0, 4'b1111, tv, dv);
            check("flood_count", 32'(buf_count), 32'(k + 1));
        end
    endtask

    initial begin
        // Reset held two cycles with all FUs requesting
        fresh();
        step(1'b0, 1'b0, 4'b1111, tv, dv);
        step(1'b0, 1'b0, 4'b1111, tv, dv);
        check("reset_ready", 32'(fu_ready), 32'd1);

        // Single result
        tv = '0; dv = '0;
        tv[0] = 5'd5; dv[0] = 32'hDEAD;
        step(1'b1, 1'b0, 4'b0001, tv, dv);
        check("single_tag", 32'(cdb_tag[0]), 32'd5);
        check("single_value", cdb_value[0], 32'hDEAD);
        idle(1);

        // Ordering across lanes and into the queue
        tv[0] = 5'd3; tv[1] = 5'd7; tv[2] = 5'd9; tv[3] = 5'd12;
        dv[0] = 32'h33; dv[1] = 32'h77; dv[2] = 32'h99; dv[3] = 32'hCC;
        step(1'b1, 1'b0, 4'b1111, tv, dv);
        check("order_lane2", 32'(cdb_tag[2]), 32'd9);
        idle(1);
        check("order_tail", 32'(cdb_tag[0]), 32'd12);
        idle(1);

        // Backpressure up to a full queue, then drain
        flood(8);
        check("full_ready", 32'(fu_ready), 32'd0);
        fresh();
        step(1'b1, 1'b0, 4'b1111, tv, dv);
        check("drain1", 32'(buf_count), 32'd5);
        idle(2);
        check("drain_empty", 32'(buf_count), 32'd0);
        idle(1);

        // Squash with a half-full queue
        flood(4);
        fresh();
        step(1'b1, 1'b1, 4'b1111, tv, dv);
        check("squash_valid", 32'(cdb_valid), 32'd0);
        idle(3);

        // Wrap-around: pointers cross the end of the buffer
        flood(8);
        idle(4);
        flood(6);
        idle(4);

        // Random traffic with occasional squash and reset
        for (int k = 0; k < 400; k++) begin
            fresh();
            step(($urandom_range(99) != 0), ($urandom_range(39) == 0),
                 4'($urandom_range(15)), tv, dv);
        end
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cdb_broadcast.md
CDB_BROADCAST -- requirements
Module: cdb_broadcast

Interface
REQ-001 SHALL have parameter NUM_FU, default 4: number of FU completion ports.
REQ-002 SHALL have parameter CDB_LANES, default 3: broadcast lanes per cycle, matching the 3-wide CDB_RS_PACKET consumed by RS/ROB/MT.
REQ-003 SHALL have parameter BUF_DEPTH, default 8: overflow queue entries, power of two, at least NUM_FU.
REQ-004 SHALL have parameter TAG_W, default $clog2(`ROBLEN): ROB tag width.
REQ-005 SHALL have port clock  input  1  the single clock; all state updates on its posedge.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-007 SHALL have port squash_flag  input  1  branch mispredict flush.
REQ-008 SHALL have port fu_valid  input  NUM_FU  completion request per FU.
REQ-009 SHALL have port fu_tag  input  NUM_FU x TAG_W  ROB tag of each result.
REQ-010 SHALL have port fu_value  input  NUM_FU x `XLEN  result value.
REQ-011 SHALL have port fu_ready  output  1  all FU ports may present results this cycle.
REQ-012 SHALL have port cdb_valid  output  CDB_LANES  lane broadcast valid (registered).
REQ-013 SHALL have port cdb_tag  output  CDB_LANES x TAG_W  broadcast tag (registered).
REQ-014 SHALL have port cdb_value  output  CDB_LANES x `XLEN  broadcast value (registered).
REQ-015 SHALL have port buf_count  output  $clog2(BUF_DEPTH)+1  queue occupancy (registered).

Function
REQ-016 SHALL drive fu_ready = (buf_count < BUF_DEPTH), a function of registered state only, with no dependency on fu_valid.
REQ-017 SHALL accept port i in a cycle iff fu_valid[i] & fu_ready & reset & ~squash_flag; unaccepted requests are ignored and the FU holds them.
REQ-018 SHALL form a per-cycle candidate list: queued entries oldest first, then this cycle's accepted results in ascending FU index.
REQ-019 SHALL load the first P = min(buf_count + accepted, CDB_LANES) candidates into lanes 0..P-1 at the next posedge, lane 0 oldest.
REQ-020 SHALL clear unused lanes at that posedge: valid 0, tag 0, value 0.
REQ-021 SHALL write the remaining candidates to the queue in order: next buf_count = buf_count + accepted - P.
REQ-022 SHALL give a result one cycle of latency from acceptance to cdb_valid when no older entries precede it; queued entries wait one extra cycle per CDB_LANES older entries.
REQ-023 SHALL broadcast each accepted result exactly once, and never reorder results accepted in different cycles.
REQ-024 SHALL implement the queue as a circular buffer with head/tail pointers wrapping modulo BUF_DEPTH; multiple pushes and pops occur in the same cycle.
REQ-025 SHALL never overflow: since NUM_FU - CDB_LANES <= 1 at the defaults, buf_count grows by at most 1 per cycle and saturates at BUF_DEPTH.
REQ-026 SHALL, when the queue is full (buf_count = BUF_DEPTH), accept nothing, pop CDB_LANES entries, and set next buf_count = BUF_DEPTH - CDB_LANES.
REQ-027 SHALL, when squash_flag = 1 at a posedge with reset high, empty the queue, reset both pointers to 0, clear all lanes and drop that cycle's inputs; squash has priority over acceptance and drain.

Reset
REQ-028 SHALL, when reset = 0 at a posedge, set buf_count 0, head/tail 0, cdb_valid 0, cdb_tag 0 and cdb_value 0; inputs are ignored while reset is low.
REQ-029 SHALL give reset priority over squash_flag, with fu_ready = 1 on the first cycle after reset.
REQ-030 SHALL, on reset asserted mid-operation, discard queued entries without broadcasting them.

Verification
REQ-031 SHALL cover reset: reset=0 for 2 cycles with fu_valid=4'b1111 -> cdb_valid=000, buf_count=0, fu_ready=1 after release.
REQ-032 SHALL cover a single result: fu_valid=0001, tag 5, value 32'hDEAD -> next cycle lane0 valid, tag 5, value DEAD; lanes 1-2 invalid; buf_count 0.
REQ-033 SHALL cover ordering: fu_valid=1111 with tags 3, 7, 9, 12 -> next cycle lanes = 3, 7, 9 and buf_count=1; following idle cycle lane0 = 12.
REQ-034 SHALL cover backpressure: fu_valid=1111 for 8 consecutive cycles -> buf_count 1..8, fu_ready=0 at count 8; then idle -> buf_count 5, 2, 0 and all tags broadcast in acceptance order.
REQ-035 SHALL cover squash: buf_count=4, squash_flag=1 with fu_valid=1111 -> next cycle buf_count=0, cdb_valid=000, and none of those tags broadcast afterward.
REQ-036 SHALL cover wrap-around: after the REQ-034 drain, repeat with fresh tags -> head/tail cross index 7->0 with order preserved.
